// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and encodings for the instruction memory arbiter
package imem_pkg;
    localparam int IMEM_DEPTH_LOG2 = 8;
    localparam int IMEM_STARVE_MAX = 4;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    typedef enum logic {ST_BOOT, ST_RUN} state_t;
    typedef enum logic {OWN_IF, OWN_LD} owner_t;
endpackage

// File: rtl/imem_addr_chk.sv
// imem_addr_chk: alignment/range fault detection and word index extraction
module imem_addr_chk import imem_pkg::*; #(
    parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
    input  logic [31:0]           i_addr,
    output logic                  o_fault,
    output logic [DEPTH_LOG2-1:0] o_idx
);
    assign o_fault = (|i_addr[1:0]) || (|i_addr[31:DEPTH_LOG2+2]);
    assign o_idx   = i_addr[DEPTH_LOG2+1:2];
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory between fetch and the loader, with a boot phase
module imem_arbiter import imem_pkg::*; #(
    parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2,
    parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_if_req,
    input  logic [31:0]           i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [31:0]           o_if_rdata,
    output logic                  o_if_err,
    input  logic                  i_ld_req,
    input  logic                  i_ld_we,
    input  logic [31:0]           i_ld_addr,
    input  logic [31:0]           i_ld_wdata,
    output logic                  o_ld_gnt,
    output logic                  o_ld_rvalid,
    output logic [31:0]           o_ld_rdata,
    input  logic                  i_boot_done,
    input  logic                  i_boot_start,
    output logic                  o_cpu_hold,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [DEPTH_LOG2-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    state_t                r_state, w_state_nx;
    owner_t                r_rd_own;
    logic                  r_cpu_hold, r_rd_vld, r_if_flt, r_ld_flt;
    logic [CW-1:0]         r_starve;
    logic [31:0]           r_if_rdata, r_ld_rdata;
    logic                  w_if_flt, w_ld_flt, w_starved, w_if_mem, w_ld_mem;
    logic                  w_if_rsp_m, w_if_rsp_f, w_ld_rsp_m, w_ld_rsp_f;
    logic [DEPTH_LOG2-1:0] w_if_idx, w_ld_idx;

    imem_addr_chk #(.DEPTH_LOG2(DEPTH_LOG2)) u_if_chk (
        .i_addr (i_if_addr),
        .o_fault(w_if_flt),
        .o_idx  (w_if_idx)
    );

    imem_addr_chk #(.DEPTH_LOG2(DEPTH_LOG2)) u_ld_chk (
        .i_addr (i_ld_addr),
        .o_fault(w_ld_flt),
        .o_idx  (w_ld_idx)
    );

    // boot_start beats boot_done so a reprogram request is never lost
    always_comb begin
        w_state_nx = r_state;
        if (i_boot_start)
            w_state_nx = ST_BOOT;
        else if (i_boot_done)
            w_state_nx = ST_RUN;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_nx;
    end

    // grants and memory drive; a faulting fetch leaves the port free for the loader
    always_comb begin
        w_starved   = (r_starve == CW'(STARVE_MAX));
        o_if_gnt    = rst_n && (r_state == ST_RUN) && i_if_req && !(i_ld_req && w_starved);
        o_ld_gnt    = rst_n && i_ld_req && (!o_if_gnt || w_if_flt);
        w_if_mem    = o_if_gnt && !w_if_flt;
        w_ld_mem    = o_ld_gnt && !w_ld_flt;
        o_mem_en    = w_if_mem || w_ld_mem;
        o_mem_we    = !w_if_mem && w_ld_mem && i_ld_we;
        o_mem_addr  = w_if_mem ? w_if_idx : w_ld_idx;
        o_mem_wdata = i_ld_wdata;
    end

    // response routing; rdata falls back to the held value when nothing is returned
    always_comb begin
        w_if_rsp_m  = rst_n && r_rd_vld && (r_rd_own == OWN_IF);
        w_ld_rsp_m  = rst_n && r_rd_vld && (r_rd_own == OWN_LD);
        w_if_rsp_f  = rst_n && r_if_flt;
        w_ld_rsp_f  = rst_n && r_ld_flt;
        o_if_rvalid = w_if_rsp_m || w_if_rsp_f;
        o_if_err    = w_if_rsp_f;
        o_if_rdata  = w_if_rsp_f ? NOP_INST : (w_if_rsp_m ? i_mem_rdata : r_if_rdata);
        o_ld_rvalid = w_ld_rsp_m || w_ld_rsp_f;
        o_ld_rdata  = w_ld_rsp_f ? 32'h0 : (w_ld_rsp_m ? i_mem_rdata : r_ld_rdata);
        o_cpu_hold  = r_cpu_hold;
    end

    // hold line, starvation counter and one-deep response pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cpu_hold <= 1'b1;
            r_starve   <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_own   <= OWN_IF;
            r_if_flt   <= 1'b0;
            r_ld_flt   <= 1'b0;
            r_if_rdata <= '0;
            r_ld_rdata <= '0;
        end else begin
            r_cpu_hold <= (w_state_nx == ST_BOOT);
            r_starve   <= (!i_ld_req || o_ld_gnt) ? '0 : (w_starved ? r_starve : r_starve + 1'b1);
            r_rd_vld   <= o_mem_en && !o_mem_we;
            r_rd_own   <= w_if_mem ? OWN_IF : OWN_LD;
            r_if_flt   <= o_if_gnt && w_if_flt;
            r_ld_flt   <= o_ld_gnt && w_ld_flt && !i_ld_we;
            r_if_rdata <= o_if_rdata;
            r_ld_rdata <= o_ld_rdata;
        end
    end
endmodule
